// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx byte port between NUM_SRC sources.
// Grants are held for a whole message; a length guard force-releases runaway sources.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_BYTES = 32,
  localparam int unsigned IDW      = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 msg_trunc
);

  localparam logic [7:0] LastIdx = 8'(MAX_BYTES - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]     byte_cnt_q, byte_cnt_d;
  logic           trunc_q, trunc_d;

  logic [7:0]     src_byte [NUM_SRC];
  logic [IDW-1:0] pick, cand;
  logic           found;
  logic           xfer;

  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_byte[i] = src_data[8*i +: 8];
    end
  end

  // First valid source after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    pick  = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && src_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    trunc_d    = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = src_byte[grant_q];
    src_ready  = '0;
    xfer       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|src_valid) begin
          grant_d    = pick;
          byte_cnt_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        tx_valid           = src_valid[grant_q];
        src_ready[grant_q] = tx_ready;
        xfer               = tx_valid && tx_ready;
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (src_last[grant_q] || byte_cnt_q == LastIdx) begin
            state_d    = StIdle;
            rr_ptr_d   = grant_q;
            byte_cnt_d = '0;
            // A real last byte wins over the guard.
            trunc_d    = !src_last[grant_q];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= IDW'(NUM_SRC - 1);
      byte_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign busy      = (state_q == StSend);
  assign grant_id  = grant_q;
  assign msg_trunc = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: per-source byte queues feed the DUT and a
// message-level reference model predicts every cycle's outputs.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned MAX_BYTES = 32;
  localparam int unsigned IDW       = $clog2(NUM_SRC);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 msg_trunc;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .MAX_BYTES(MAX_BYTES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_last (src_last),
    .src_ready(src_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .busy     (busy),
    .grant_id (grant_id),
    .msg_trunc(msg_trunc)
  );

  // Pending bytes per source; head is what the source currently offers.
  logic [7:0] q_data [NUM_SRC][$];
  logic       q_last [NUM_SRC][$];

  int unsigned valid_pct = 100;
  int unsigned ready_pct = 100;
  bit          rand_rst  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the port, bytes sent in this message, last winner.
  int m_owner;
  int m_cnt;
  int m_ptr;
  int m_gid;
  bit m_trunc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = NUM_SRC - 1;
    m_gid   = 0;
    m_trunc = 1'b0;
  endtask

  task automatic push_msg(input int s, input int len, input int base, input bit with_last);
    for (int j = 0; j < len; j++) begin
      q_data[s].push_back(8'(base + 7 * j));
      q_last[s].push_back(with_last && (j == len - 1));
    end
  endtask

  task automatic drive();
    rst = rand_rst && ($urandom_range(199) == 0);
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!rst && q_data[i].size() > 0 && $urandom_range(99) < valid_pct) begin
        src_valid[i]       = 1'b1;
        src_data[8*i +: 8] = q_data[i][0];
        src_last[i]        = q_last[i][0];
      end else begin
        src_valid[i]       = 1'b0;
        src_data[8*i +: 8] = 8'($urandom);
        src_last[i]        = 1'($urandom_range(1));
      end
    end
    tx_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic cycle_check();
    logic [NUM_SRC-1:0] e_ready;
    logic               e_txv;
    logic               lst;
    int                 owner;
    owner   = m_owner;
    e_txv   = (owner >= 0) && src_valid[owner];
    e_ready = '0;
    if (owner >= 0 && tx_ready) e_ready[owner] = 1'b1;

    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("msg_trunc", 32'(msg_trunc), 32'(m_trunc));
    chk("tx_valid", 32'(tx_valid), 32'(e_txv));
    chk("src_ready", 32'(src_ready), 32'(e_ready));
    if (e_txv) chk("tx_data", 32'(tx_data), 32'(q_data[owner][0]));

    if (rst) begin
      model_reset();
    end else begin
      m_trunc = 1'b0;
      if (owner < 0) begin
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
          int idx;
          idx = (m_ptr + k) % NUM_SRC;
          if (m_owner < 0 && src_valid[idx]) begin
            m_owner = idx;
            m_gid   = idx;
            m_cnt   = 0;
          end
        end
      end else if (e_txv && tx_ready) begin
        lst = q_last[owner].pop_front();
        void'(q_data[owner].pop_front());
        m_cnt++;
        if (lst || m_cnt == int'(MAX_BYTES)) begin
          m_trunc = !lst;
          m_ptr   = owner;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      #1 drive();
      @(negedge clk);
      cycle_check();
      @(posedge clk);
    end
  endtask

  initial begin
    logic [7:0] hello [13];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0A};
    rst       = 1'b1;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    tx_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Single source, full throughput.
    for (int j = 0; j < 13; j++) begin
      q_data[2].push_back(hello[j]);
      q_last[2].push_back(j == 12);
    end
    run(20);

    // Three contenders with short messages: strict rotation expected.
    for (int r = 0; r < 2; r++) begin
      push_msg(0, 3, 8'h10, 1'b1);
      push_msg(1, 3, 8'h40, 1'b1);
      push_msg(3, 3, 8'h80, 1'b1);
    end
    run(30);

    // Source 1 never ends its messages, so the length guard must cut it.
    push_msg(1, 70, 8'h05, 1'b0);
    push_msg(2, 4, 8'hA0, 1'b1);
    run(90);

    // Random traffic with backpressure, stalls and occasional resets.
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      for (int j = 0; j < 300; j++) begin
        q_data[s].push_back(8'($urandom));
        q_last[s].push_back((s != 1) && ($urandom_range(5) == 0));
      end
    end
    valid_pct = 75;
    ready_pct = 60;
    rand_rst  = 1'b1;
    run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
